// File: rtl/bit_packer.sv
// Packs 1..16-bit fields MSB-first into 16-bit words with a valid/ready output.
// A flush emits the residual bits as a zero-padded final word flagged by out_last.
module bit_packer #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    input  logic [4:0]   in_len,
    input  logic         flush_req,
    output logic         flush_done,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic         out_last
);

    typedef enum logic {
        ACCUM = 1'b0,
        FLUSH = 1'b1
    } state_t;

    state_t       state_q, state_d;
    logic [15:0]  acc_q, acc_d;
    logic [3:0]   cnt_q, cnt_d;
    logic         outValid_q, outValid_d;
    logic [15:0]  outData_q, outData_d;
    logic         outLast_q, outLast_d;
    logic         flushDone_q, flushDone_d;

    logic         outFree;
    logic         accept;
    logic [4:0]   fieldLen;
    logic [15:0]  fieldMask;
    logic [4:0]   cntSum;
    logic [5:0]   shiftAmt;
    logic [31:0]  combined;

    assign outFree = ~outValid_q | out_ready;

    // A pending flush request wins over a field offered in the same cycle,
    // so the handshake is withheld rather than silently dropping the field.
    assign in_ready = ~reset & (state_q == ACCUM) & outFree & ~flush_req;
    assign accept   = in_valid & in_ready;

    assign fieldLen  = in_len[4] ? 5'd16 : in_len;
    assign fieldMask = fieldLen[4] ? 16'hFFFF : ((16'h1 << fieldLen[3:0]) - 16'h1);
    assign cntSum    = {1'b0, cnt_q} + fieldLen;
    assign shiftAmt  = 6'd32 - {1'b0, cntSum};

    // The 32-bit window holds the residual on top and the new field directly
    // below it; the upper half is a finished word when cntSum reaches 16.
    assign combined = {acc_q, 16'h0000} | ({16'h0000, in_data & fieldMask} << shiftAmt);

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        outValid_d  = outValid_q;
        outData_d   = outData_q;
        outLast_d   = outLast_q;
        flushDone_d = 1'b0;

        if (outValid_q && out_ready) begin
            outValid_d = 1'b0;
        end

        case (state_q)
            ACCUM: begin
                if (flush_req) begin
                    state_d = FLUSH;
                end else if (accept && (fieldLen != 5'd0)) begin
                    cnt_d = cntSum[3:0];
                    if (cntSum[4]) begin
                        outData_d  = combined[31:16];
                        outValid_d = 1'b1;
                        outLast_d  = 1'b0;
                        acc_d      = combined[15:0];
                    end else begin
                        acc_d = combined[31:16];
                    end
                end
            end
            FLUSH: begin
                if (cnt_q == 4'd0) begin
                    flushDone_d = 1'b1;
                    state_d     = ACCUM;
                end else if (outFree) begin
                    outData_d   = acc_q & ~(16'hFFFF >> cnt_q);
                    outValid_d  = 1'b1;
                    outLast_d   = 1'b1;
                    cnt_d       = 4'd0;
                    acc_d       = 16'h0000;
                    flushDone_d = 1'b1;
                    state_d     = ACCUM;
                end
            end
            default: state_d = ACCUM;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ACCUM;
            acc_q       <= 16'h0000;
            cnt_q       <= 4'd0;
            outValid_q  <= 1'b0;
            outData_q   <= 16'h0000;
            outLast_q   <= 1'b0;
            flushDone_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            outValid_q  <= outValid_d;
            outData_q   <= outData_d;
            outLast_q   <= outLast_d;
            flushDone_q <= flushDone_d;
        end
    end

    assign out_valid  = outValid_q;
    assign out_data   = outData_q;
    assign out_last   = outLast_q;
    assign flush_done = flushDone_q;

endmodule
